// File: rtl/debounce_array_if.sv
// debounce_array_if
// Groups the per-channel signals of the debounce array into one bundle.
//   org        raw asynchronous inputs, one bit per channel
//   debounced  accepted stable level per channel
//   rise       one-cycle pulse on an accepted 0->1 change
//   fall       one-cycle pulse on an accepted 1->0 change
//   hold       one-cycle long-press / auto-repeat pulses
//   phase_dbg  per-channel hold phase (0 = FIRST, 1 = REPEAT, 2 = IDLE)
// Modports: master drives org and observes the rest; slave is the conditioner.
// All outputs are plain registered levels/pulses; there is no valid/ready
// handshake, every bit is meaningful on every rising clock edge.
interface debounce_array_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]      org;
    logic [WIDTH-1:0]      debounced;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      fall;
    logic [WIDTH-1:0]      hold;
    logic [WIDTH-1:0][1:0] phase_dbg;

    modport master (
        output org,
        input  debounced,
        input  rise,
        input  fall,
        input  hold,
        input  phase_dbg
    );

    modport slave (
        input  org,
        output debounced,
        output rise,
        output fall,
        output hold,
        output phase_dbg
    );
endinterface

// File: rtl/debounce_array.sv
// debounce_array
// WIDTH independent input conditioners. Each lane synchronises its raw input,
// accepts a new level only after N consecutive mismatching cycles (any bounce
// back restarts the count), emits registered rise/fall pulses in the cycle the
// new level appears, and produces long-press / auto-repeat hold pulses.
// Ports:
//   clk        sole clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        debounce_array_if slave modport (org in; debounced, rise,
//              fall, hold, phase_dbg out)
module debounce_array #(
    parameter int WIDTH       = 4,
    parameter int N           = 20,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_N      = 0,
    parameter int REPEAT_N    = 0
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    debounce_array_if.slave  bus
);

    localparam int CW   = $clog2(N + 1);
    localparam int HMAX = (HOLD_N > REPEAT_N) ? HOLD_N : REPEAT_N;
    localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_N > 0) ? HOLD_N - 1 : 0);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_N > 0) ? REPEAT_N - 1 : 0);

    typedef enum logic [1:0] {
        PH_FIRST  = 2'd0,
        PH_REPEAT = 2'd1,
        PH_IDLE   = 2'd2
    } phase_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   s;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   deb_q, deb_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], bus.org[i]};
        end

        // Stability counter: any cycle where the synchronised input agrees
        // with the accepted level throws away the progress made so far.
        always_comb begin
            deb_d  = deb_q;
            cnt_d  = cnt_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (s == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_d  = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                deb_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                deb_q  <= deb_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign bus.debounced[i] = deb_q;
        assign bus.rise[i]      = rise_q;
        assign bus.fall[i]      = fall_q;

        if (HOLD_N > 0) begin : g_hold
            logic [HW-1:0] hcnt_q, hcnt_d;
            phase_e        ph_q, ph_d;
            logic          hold_q, hold_d;

            // Hold timing starts from the rise edge: the counter is held at
            // zero while the level is low and in the rise cycle itself. A fall
            // being registered this cycle wins over any pending pulse.
            always_comb begin
                hcnt_d = hcnt_q;
                ph_d   = ph_q;
                hold_d = 1'b0;
                if (!deb_q || rise_d || fall_d) begin
                    hcnt_d = '0;
                    ph_d   = PH_FIRST;
                end else begin
                    case (ph_q)
                        PH_FIRST: begin
                            if (hcnt_q == HOLD_LAST) begin
                                hold_d = 1'b1;
                                hcnt_d = '0;
                                ph_d   = (REPEAT_N > 0) ? PH_REPEAT : PH_IDLE;
                            end else begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end
                        PH_REPEAT: begin
                            if (hcnt_q == REP_LAST) begin
                                hold_d = 1'b1;
                                hcnt_d = '0;
                            end else begin
                                hcnt_d = hcnt_q + 1'b1;
                            end
                        end
                        default: begin
                            hcnt_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    hcnt_q <= '0;
                    ph_q   <= PH_FIRST;
                    hold_q <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    ph_q   <= ph_d;
                    hold_q <= hold_d;
                end
            end

            assign bus.hold[i]      = hold_q;
            assign bus.phase_dbg[i] = ph_q;
        end else begin : g_no_hold
            assign bus.hold[i]      = 1'b0;
            assign bus.phase_dbg[i] = PH_FIRST;
        end
    end

endmodule

// File: tb/tb_debounce_array.sv
module tb_debounce_array;

  localparam int WIDTH = 4;

  logic clk;
  logic sys_rst_n;
  int   n_checks;
  int   n_pass;

  debounce_array_if #(.WIDTH(WIDTH)) bus ();

  debounce_array #(
    .WIDTH      (WIDTH),
    .N          (4),
    .SYNC_STAGES(2),
    .HOLD_N     (10),
    .REPEAT_N   (5)
  ) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    bus.org   = '0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic [3:0] r,
                            input logic [3:0] f, input logic [3:0] h);
    check({tag, ".deb"},  32'(bus.debounced), 32'(d));
    check({tag, ".rise"}, 32'(bus.rise),      32'(r));
    check({tag, ".fall"}, 32'(bus.fall),      32'(f));
    check({tag, ".hold"}, 32'(bus.hold),      32'(h));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_d, exp_r, exp_f, exp_h;
    n_checks  = 0;
    n_pass    = 0;
    sys_rst_n = 1'b0;
    bus.org   = '0;
    #2;
    expect_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    check("reset.phase", 32'(bus.phase_dbg), 32'h0);
    do_reset();
    tick();
    expect_out("idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Clean press on channel 0: accepted at edge 6.
    do_reset();
    bus.org = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_r = (e == 6) ? 4'b0001 : 4'b0000;
      expect_out($sformatf("press.e%0d", e), exp_d, exp_r, 4'h0, 4'h0);
    end

    // Bounce on channel 1: 3 high, 1 low, then steady high.
    do_reset();
    bus.org = 4'b0010;
    for (int e = 1; e <= 3; e++) begin
      tick();
      expect_out($sformatf("bounce.pre%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
    end
    bus.org = 4'b0000;
    tick();
    expect_out("bounce.low", 4'h0, 4'h0, 4'h0, 4'h0);
    bus.org = 4'b0010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0010 : 4'b0000;
      exp_r = (e == 6) ? 4'b0010 : 4'b0000;
      expect_out($sformatf("bounce.e%0d", e), exp_d, exp_r, 4'h0, 4'h0);
    end

    // Long press on channel 2 with auto-repeat, then release.
    do_reset();
    bus.org = 4'b0100;
    for (int e = 1; e <= 6; e++) tick();
    expect_out("long.R", 4'b0100, 4'b0100, 4'h0, 4'h0);
    for (int k = 1; k <= 60; k++) begin
      if (k == 41) bus.org = 4'b0000;
      tick();
      // Release is sampled at R+41, so the level drops at R+46; the pulse
      // at R+45 still falls inside the accepted-high window.
      exp_d = (k <= 45) ? 4'b0100 : 4'b0000;
      exp_f = (k == 46) ? 4'b0100 : 4'b0000;
      exp_h = (k >= 10 && k <= 45 && (k % 5) == 0) ? 4'b0100 : 4'b0000;
      expect_out($sformatf("long.R+%0d", k), exp_d, 4'h0, exp_f, exp_h);
    end

    // Channel 3 released on the same edge channel 0 is pressed.
    do_reset();
    bus.org = 4'b1000;
    for (int e = 1; e <= 7; e++) tick();
    expect_out("simul.pre", 4'b1000, 4'h0, 4'h0, 4'h0);
    bus.org = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0001 : 4'b1000;
      exp_r = (e == 6) ? 4'b0001 : 4'b0000;
      exp_f = (e == 6) ? 4'b1000 : 4'b0000;
      expect_out($sformatf("simul.e%0d", e), exp_d, exp_r, exp_f, 4'h0);
    end

    // Glitch of 3 cycles on channel 1 is rejected.
    do_reset();
    bus.org = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) bus.org = 4'b0000;
      tick();
      expect_out($sformatf("glitch3.e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0);
    end
    // A 4-cycle pulse is accepted, then released 4 cycles later.
    bus.org = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) bus.org = 4'b0000;
      tick();
      exp_d = (e >= 6 && e < 10) ? 4'b0010 : 4'b0000;
      exp_r = (e == 6)  ? 4'b0010 : 4'b0000;
      exp_f = (e == 10) ? 4'b0010 : 4'b0000;
      expect_out($sformatf("pulse4.e%0d", e), exp_d, exp_r, exp_f, 4'h0);
    end

    // Reset while channel 0 is debounced high; input stays high.
    do_reset();
    bus.org = 4'b0001;
    for (int e = 1; e <= 7; e++) tick();
    expect_out("rstmid.pre", 4'b0001, 4'h0, 4'h0, 4'h0);
    sys_rst_n = 1'b0;
    #1;
    expect_out("rstmid.async", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    expect_out("rstmid.held", 4'h0, 4'h0, 4'h0, 4'h0);
    sys_rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_d = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_r = (e == 6) ? 4'b0001 : 4'b0000;
      expect_out($sformatf("rstmid.e%0d", e), exp_d, exp_r, 4'h0, 4'h0);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
